// File: rtl/imm_gen_if.sv
// Valid/ready bus between the decoder, the immediate-generation stage and its consumer.
// The master drives instructions in and takes results out; the slave is the stage itself.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_inst, in_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag
  );

  modport slave (
    input  flush, in_valid, in_inst, in_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with a 2-entry skid buffer (main M, skid K).
// Results leave from M; K catches the one extra accept that lands while M is stalled.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  imm_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_Z  = 3'd6,
    FMT_SH = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = v[31] ? '1 : '0;
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  logic [31:0]     inst;
  logic [31:0]     shamt;
  logic [XLEN-1:0] new_imm;
  logic            unused_opcode_bits;
  entry_t          new_entry;

  entry_t m_q, m_d, k_q, k_d;
  logic   m_valid, m_valid_d, k_valid, k_valid_d;
  logic   accept, xfer;

  assign inst               = bus.in_inst;
  assign unused_opcode_bits = ^inst[6:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    new_imm = '0;
    shamt   = {26'b0, inst[25:20]};
    if (XLEN == 32) shamt[5] = 1'b0;
    case (fmt_e'(bus.in_type))
      FMT_R:  new_imm = '0;
      FMT_I:  new_imm = sext32({{20{inst[31]}}, inst[31:20]});
      FMT_S:  new_imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      FMT_B:  new_imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      FMT_U:  new_imm = sext32({inst[31:12], 12'b0});
      FMT_J:  new_imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      FMT_Z:  new_imm = zext32({27'b0, inst[19:15]});
      FMT_SH: new_imm = zext32(shamt);
      default: new_imm = '0;
    endcase
  end

  assign new_entry = '{imm: new_imm, fmt: bus.in_type, tag: bus.in_tag};

  // in_ready depends only on the K register, never on out_ready.
  assign accept = bus.in_valid && !k_valid;
  assign xfer   = m_valid && bus.out_ready;

  always_comb begin
    m_valid_d = m_valid;
    k_valid_d = k_valid;
    m_d       = m_q;
    k_d       = k_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (k_valid) begin
      // K is full, so in_ready is low and only the K->M refill can happen.
      if (xfer) begin
        m_d       = k_q;
        k_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid || xfer) begin
        m_d       = new_entry;
        m_valid_d = 1'b1;
      end else begin
        k_d       = new_entry;
        k_valid_d = 1'b1;
      end
    end else if (xfer) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      // NOTE: the data registers are reset too, so the outputs never show X after reset.
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      m_valid <= m_valid_d;
      k_valid <= k_valid_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  assign bus.in_ready  = !k_valid;
  assign bus.out_valid = m_valid;
  assign bus.out_imm   = m_q.imm;
  assign bus.out_type  = m_q.fmt;
  assign bus.out_tag   = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance share the same stimulus.
// Expected immediates are hand-decoded from the instruction encodings.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] ty,
                       input logic [31:0] tag);
    b32.in_valid = v;  b32.in_inst = inst;  b32.in_type = ty;  b32.in_tag = tag;
    b64.in_valid = v;  b64.in_inst = inst;  b64.in_type = ty;  b64.in_tag = tag;
  endtask

  task automatic set_ctrl(input logic flush, input logic ready);
    b32.flush = flush;  b32.out_ready = ready;
    b64.flush = flush;  b64.out_ready = ready;
  endtask

  // One accept with out_ready=1; the result must be on the outputs one cycle later.
  task automatic send(input string name, input logic [31:0] inst, input logic [2:0] ty,
                      input logic [31:0] tag, input logic [31:0] exp32, input logic [63:0] exp64);
    drive(1'b1, inst, ty, tag);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    check({name, " valid32"}, {63'b0, b32.out_valid}, 64'd1);
    check({name, " valid64"}, {63'b0, b64.out_valid}, 64'd1);
    check({name, " imm32"},   {32'b0, b32.out_imm}, {32'b0, exp32});
    check({name, " imm64"},   b64.out_imm, exp64);
    check({name, " type"},    {61'b0, b32.out_type}, {61'b0, ty});
    check({name, " tag"},     {32'b0, b64.out_tag}, {32'b0, tag});
  endtask

  initial begin
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    set_ctrl(1'b0, 1'b1);
    #2;
    check("rst out_valid", {63'b0, b32.out_valid}, 64'd0);
    check("rst in_ready",  {63'b0, b32.in_ready}, 64'd1);
    check("rst out_imm",   b64.out_imm, 64'd0);
    check("rst out_type",  {61'b0, b32.out_type}, 64'd0);
    check("rst out_tag",   {32'b0, b32.out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Immediate formats, back-to-back issue
    send("I addi",  32'hFFF00093, 3'd1, 32'h0000_0100, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    send("B beq",   32'hFE000EE3, 3'd3, 32'h0000_0104, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    send("U pos",   32'h12345037, 3'd4, 32'h0000_0108, 32'h1234_5000, 64'h0000_0000_1234_5000);
    send("U neg",   32'h80000037, 3'd4, 32'h0000_010C, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
    send("S sw",    32'hFE112E23, 3'd2, 32'h0000_0110, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    send("J jal",   32'hFFDFF06F, 3'd5, 32'h0000_0114, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    send("Z csr",   32'hFFFF8073, 3'd6, 32'h0000_0118, 32'h0000_001F, 64'h0000_0000_0000_001F);
    send("SH sll",  32'h83F00013, 3'd7, 32'h0000_011C, 32'h0000_001F, 64'h0000_0000_0000_003F);
    send("R add",   32'h00B50533, 3'd0, 32'h0000_0120, 32'h0000_0000, 64'h0000_0000_0000_0000);
    tick();
    check("drain out_valid", {63'b0, b32.out_valid}, 64'd0);

    // Backpressure: tags 1,2,3 while the consumer stalls
    set_ctrl(1'b0, 1'b0);
    drive(1'b1, 32'h00B50533, 3'd0, 32'd1);
    tick();
    check("bp1 tag",      {32'b0, b32.out_tag}, 64'd1);
    check("bp1 in_ready", {63'b0, b32.in_ready}, 64'd1);
    drive(1'b1, 32'h00B50533, 3'd0, 32'd2);
    tick();
    check("bp2 tag",      {32'b0, b32.out_tag}, 64'd1);
    check("bp2 in_ready", {63'b0, b32.in_ready}, 64'd0);
    drive(1'b1, 32'h00B50533, 3'd0, 32'd3);
    tick();
    check("bp3 tag",      {32'b0, b32.out_tag}, 64'd1);
    check("bp3 in_ready", {63'b0, b32.in_ready}, 64'd0);
    check("bp3 valid",    {63'b0, b32.out_valid}, 64'd1);
    set_ctrl(1'b0, 1'b1);
    tick();
    check("bp out2 tag",  {32'b0, b32.out_tag}, 64'd2);
    check("bp out2 rdy",  {63'b0, b32.in_ready}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    check("bp out3 tag",  {32'b0, b64.out_tag}, 64'd3);
    check("bp out3 valid",{63'b0, b64.out_valid}, 64'd1);
    tick();
    check("bp empty",     {63'b0, b32.out_valid}, 64'd0);

    // Flush with both entries full while the consumer is ready
    set_ctrl(1'b0, 1'b0);
    drive(1'b1, 32'hFFF00093, 3'd1, 32'd4);
    tick();
    drive(1'b1, 32'hFFF00093, 3'd1, 32'd5);
    tick();
    check("fl full rdy",  {63'b0, b32.in_ready}, 64'd0);
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    set_ctrl(1'b1, 1'b1);
    tick();
    set_ctrl(1'b0, 1'b1);
    check("fl out_valid", {63'b0, b32.out_valid}, 64'd0);
    check("fl in_ready",  {63'b0, b32.in_ready}, 64'd1);
    tick();
    check("fl no refill", {63'b0, b64.out_valid}, 64'd0);

    // Flush wins over a simultaneous accept
    drive(1'b1, 32'hFFF00093, 3'd1, 32'd7);
    set_ctrl(1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    set_ctrl(1'b0, 1'b1);
    check("fl acc valid", {63'b0, b32.out_valid}, 64'd0);

    // Asynchronous reset between edges with a held entry
    set_ctrl(1'b0, 1'b0);
    drive(1'b1, 32'hFFF00093, 3'd1, 32'd8);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    check("ar pre valid", {63'b0, b32.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar out_valid", {63'b0, b32.out_valid}, 64'd0);
    check("ar out_imm",   {32'b0, b32.out_imm}, 64'd0);
    check("ar out_imm64", b64.out_imm, 64'd0);
    check("ar out_tag",   {32'b0, b32.out_tag}, 64'd0);
    check("ar in_ready",  {63'b0, b32.in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_ctrl(1'b0, 1'b1);
    drive(1'b1, 32'h12345037, 3'd4, 32'd9);
    tick();
    drive(1'b0, 32'h0, 3'd0, 32'h0);
    check("ar post valid", {63'b0, b32.out_valid}, 64'd1);
    check("ar post tag",   {32'b0, b32.out_tag}, 64'd9);
    check("ar post imm",   {32'b0, b32.out_imm}, 64'h0000_0000_1234_5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate-generation stage for the NPC decode path. It takes a raw instruction and its format type from the decoder over a valid/ready handshake. It produces an XLEN-wide immediate with a pass-through tag one cycle later, and a 2-entry skid buffer gives full throughput under backpressure. It generalises the combinational immediate generator to RV32/RV64 and adds the CSR-zimm and shift-amount formats, plus flush support.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates are extended to XLEN.
TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous and active-low
flush  input  1  synchronous pipeline flush; discards all held entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept an instruction
in_inst  input  32  raw instruction word
in_type  input  3  format: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, SH=7 (values fixed in include/defines.v)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
out_imm  output  XLEN  generated immediate
out_type  output  3  echoed format
out_tag  output  TAG_W  echoed tag

Behaviour:
- Immediate rules; s = inst[31]; "sext" means sign-extend to XLEN, "zext" means zero-extend to XLEN.
  - R: 0.
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 = s.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - Z: zext(inst[19:15]), the CSR uimm.
  - SH: zext(inst[25:20]) when XLEN=64; zext(inst[24:20]) when XLEN=32.
- The immediate is computed combinationally from in_inst/in_type and captured into storage on the accept edge. Storage holds the computed immediate, type and tag, not the raw instruction.
- Storage consists of a main output register (M) and a skid register (K), each with its own valid bit.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_valid must be held with stable data until accepted.
  - in_ready = !K.valid, taken from a register with no combinational path from out_ready.
  - out_valid = M.valid; out_* are driven from M.
- Latency: an accepted instruction appears on out_* on the next cycle when M is empty or is transferring that cycle. Sustained throughput is 1 per cycle while out_ready=1.
- Per-cycle update rules:
  - Accept, M empty or M transferring, K empty: M <= new.
  - Accept while M is held (valid && !out_ready): K <= new; in_ready drops next cycle.
  - M transferring while K valid: M <= K and K is cleared. A simultaneous accept is impossible because in_ready=0.
  - Transfer with no accept and K empty: M.valid <= 0.
- Ordering: strictly FIFO; K is never bypassed.
- flush has priority over all other events.
  - On a flush cycle, M.valid and K.valid clear at the edge; no accept and no transfer count as having occurred that cycle.
  - in_ready reads 1 on the cycle after a flush.
- Reset, asserted at any time (including mid-transfer): asynchronously forces M.valid=0, K.valid=0, out_valid=0, in_ready=1, out_imm=0, out_type=0, out_tag=0.
  - Data registers also reset, so no X values appear on outputs.
  - Release is synchronous with respect to the first edge at which rst_n is sampled high.
- X-safety: when in_type is illegal (none exist with 3 bits) or in_valid=0, storage is not written.

Test Plan:
- XLEN=32, I-type, in_inst=0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> out_valid the next cycle, out_imm=0xFFFFFFFF, out_tag echoes; with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
- B-type 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC. U-type 0x12345037 -> 0x12345000. With XLEN=64, U-type 0x80000037 -> 0xFFFFFFFF80000000.
- Z-type with inst[19:15]=0x1F -> 0x1F. SH-type with inst[25:20]=0x3F -> 0x3F at XLEN=64 and 0x1F at XLEN=32.
- Backpressure: stream tags 1,2,3 back-to-back while out_ready=0 -> tag1 in M, tag2 in K, in_ready=0 on the third cycle, tag3 is held upstream. Raising out_ready gives outputs 1,2,3 in order with no loss or duplication.
- Flush: with both entries full, pulse flush together with out_ready=1 -> no transfer counted, out_valid=0 and in_ready=1 on the next cycle.
- Async reset: drop rst_n mid-stream between clock edges -> out_valid=0 and out_imm=0 immediately. After release, the first new accept appears after 1 cycle.
